// File: rtl/display_arbiter.sv
// Two-requester arbiter for the seven-segment display: latches one message per grant and holds it for a dwell time.
// Outputs update one cycle after a grant; req_ready stays low during dwell unless an error preempts a non-error message.
module display_arbiter #(
    parameter int DWELL_CYCLES = 50_000_000,
    parameter int DWELL_W      = 26
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [15:0] req0_number,
    input  logic [15:0] req1_number,
    input  logic        req0_overflow,
    input  logic        req1_overflow,
    input  logic [3:0]  req0_error,
    input  logic [3:0]  req1_error,
    output logic [15:0] number,
    output logic        overflow,
    output logic [3:0]  error,
    output logic [1:0]  owner,
    output logic        busy
);

    localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DWELL_CYCLES - 1);

    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] cnt_next;
    logic               last;
    logic [1:0]         err_req;
    logic [1:0]         cand;
    logic [1:0]         grant;
    logic               win;

    assign err_req[0] = req_valid[0] && (req0_error != 4'h0);
    assign err_req[1] = req_valid[1] && (req1_error != 4'h0);

    // Idle: errors filter the candidate set; dwell: only errors may preempt a non-error display
    always_comb begin
        cand = 2'b00;
        if (cnt == '0) begin
            cand = (|err_req) ? err_req : req_valid;
        end else if (error == 4'h0) begin
            cand = err_req;
        end
    end

    always_comb begin
        grant = 2'b00;
        case (cand)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    assign req_ready = reset_n ? grant : 2'b00;
    assign win       = grant[1];

    always_comb begin
        cnt_next = cnt;
        if (|grant) begin
            cnt_next = DWELL_LOAD;
        end else if (cnt != '0) begin
            cnt_next = cnt - DWELL_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= '0;
            last     <= 1'b1;
            busy     <= 1'b0;
            number   <= 16'h0;
            overflow <= 1'b0;
            error    <= 4'h0;
            owner    <= 2'b00;
        end else begin
            cnt  <= cnt_next;
            busy <= (cnt_next != '0);
            if (|grant) begin
                last     <= win;
                owner    <= grant;
                number   <= win ? req1_number   : req0_number;
                overflow <= win ? req1_overflow : req0_overflow;
                error    <= win ? req1_error    : req0_error;
            end
        end
    end

endmodule
